// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I-subset controller: FSM states, opcodes,
// aluOp codes and the aluControl encoding that the ALU also decodes.
package multicycle_controller_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_t;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: (aluOp, funct3, opcode[5], funct7b5) -> aluControl.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  aluop_t      aluOp_i,
    input  logic [2:0]  funct3_i,
    input  logic        op5_i,
    input  logic        funct7b5_i,
    output alu_ctrl_t   aluControl_o
);

    always_comb begin
        aluControl_o = ALU_ADD;
        case (aluOp_i)
            ALUOP_ADD: aluControl_o = ALU_ADD;
            ALUOP_SUB: aluControl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type (opcode[5]=1) can subtract; addi ignores instr[30].
                    3'b000:  aluControl_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  aluControl_o = ALU_SLL;
                    3'b010:  aluControl_o = ALU_SLT;
                    3'b100:  aluControl_o = ALU_XOR;
                    3'b101:  aluControl_o = ALU_SRL;
                    3'b110:  aluControl_o = ALU_OR;
                    3'b111:  aluControl_o = ALU_AND;
                    default: aluControl_o = ALU_ADD;
                endcase
            end
            default: aluControl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I-subset core. Define MC_BRANCH_NE_EN to let the
// branch state also execute bne (funct3=001).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CTRL_WIDTH  = 3,
    parameter int STATE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    output logic                  pcWrite,
    output logic                  adrSrc,
    output logic                  memWrite,
    output logic                  irWrite,
    output logic                  regWrite,
    output logic [1:0]            resultSrc,
    output logic [1:0]            aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic [1:0]            immSrc,
    output logic [CTRL_WIDTH-1:0] aluControl,
    output logic                  illegalOp
);

    logic [STATE_WIDTH-1:0] state_q, state_d;
    aluop_t    aluOp;
    alu_ctrl_t alu_ctrl;
    logic      pcUpdate, branch, taken;
    logic      memWrite_c, irWrite_c, regWrite_c, illegal_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        adrSrc     = 1'b0;
        memWrite_c = 1'b0;
        irWrite_c  = 1'b0;
        regWrite_c = 1'b0;
        resultSrc  = 2'b00;
        aluSrcA    = 2'b00;
        aluSrcB    = 2'b00;
        aluOp      = ALUOP_ADD;
        pcUpdate   = 1'b0;
        branch     = 1'b0;
        illegal_c  = 1'b0;
        immSrc     = imm_src(opcode);
        case (state_q)
            S_FETCH: begin
                irWrite_c = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                pcUpdate  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc  = 2'b01;
                regWrite_c = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc     = 1'b1;
                memWrite_c = 1'b1;
            end
            S_EXECUTER: begin
                aluSrcA = 2'b10;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: regWrite_c = 1'b1;
            S_BEQ: begin
                aluSrcA = 2'b10;
                aluOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                aluSrcA  = 2'b01;
                aluSrcB  = 2'b10;
                pcUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            default: immSrc = 2'b00;
        endcase
    end

`ifdef MC_BRANCH_NE_EN
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            default: taken = 1'b0;
        endcase
    end
`else
    assign taken = zero;
`endif

    multicycle_controller_alu_decoder u_alu_decoder (
        .aluOp_i      (aluOp),
        .funct3_i     (funct3),
        .op5_i        (opcode[5]),
        .funct7b5_i   (funct7b5),
        .aluControl_o (alu_ctrl)
    );

    // Write enables are masked by the raw reset so nothing can commit while it is held.
    assign pcWrite    = ~reset & (pcUpdate | (branch & taken));
    assign memWrite   = ~reset & memWrite_c;
    assign irWrite    = ~reset & irWrite_c;
    assign regWrite   = ~reset & regWrite_c;
    assign illegalOp  = ~reset & illegal_c;
    assign aluControl = CTRL_WIDTH'(alu_ctrl);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected output
// sequences built from the instruction's semantics, plus randomized instruction streams.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalOp;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] rs, a, b, imm;
        logic [2:0] alu;
        logic       ill;
    } obs_t;

    obs_t obs;
    obs_t exp_q[$];

    assign obs = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
                  aluSrcA, aluSrcB, immSrc, aluControl, illegalOp};

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
        .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .immSrc(immSrc), .aluControl(aluControl), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;

    function automatic logic [1:0] m_imm(input logic [6:0] op);
        if (op == SW)      return 2'b01;
        else if (op == BR) return 2'b10;
        else if (op == JL) return 2'b11;
        else               return 2'b00;
    endfunction

    // Operation the instruction asks the ALU to perform in its execute cycle.
    function automatic logic [2:0] m_op(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (op == RT && f7) ? SUB : ADD;
            3'd1:    return SLL;
            3'd2:    return SLT;
            3'd4:    return XOR_;
            3'd5:    return SRL;
            3'd6:    return OR_;
            3'd7:    return AND_;
            default: return ADD;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic z);
`ifdef MC_BRANCH_NE_EN
        if (f3 == 3'd0)      return z;
        else if (f3 == 3'd1) return !z;
        else                 return 1'b0;
`else
        return z;
`endif
    endfunction

    function automatic obs_t rec(input logic pcw, adr, memw, irw, regw,
                                 input logic [1:0] rs, a, b, imm,
                                 input logic [2:0] alu, input logic ill);
        obs_t r;
        r = {pcw, adr, memw, irw, regw, rs, a, b, imm, alu, ill};
        return r;
    endfunction

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        logic [1:0] im;
        logic       known;
        im = m_imm(op);
        known = (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BR) || (op == JL);
        exp_q.delete();
        exp_q.push_back(rec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, ADD, 0));
        exp_q.push_back(rec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, ADD, !known));
        if (op == LW || op == SW)
            exp_q.push_back(rec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ADD, 0));
        if (op == LW) begin
            exp_q.push_back(rec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 0));
            exp_q.push_back(rec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, ADD, 0));
        end
        if (op == SW)
            exp_q.push_back(rec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 0));
        if (op == RT)
            exp_q.push_back(rec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, m_op(op, f3, f7), 0));
        if (op == IT)
            exp_q.push_back(rec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, m_op(op, f3, f7), 0));
        if (op == BR)
            exp_q.push_back(rec(m_taken(f3, z), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, SUB, 0));
        if (op == JL)
            exp_q.push_back(rec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, ADD, 0));
        if (op == RT || op == IT || op == JL)
            exp_q.push_back(rec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, ADD, 0));
    endtask

    // Entered just after a rising edge with the FSM in FETCH; checks up to ncyc cycles (0 = all).
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int ncyc);
        int lim;
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
        build(op, f3, f7, z);
        lim = (ncyc == 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b required %b", name, i + 1, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        obs_t e;
        reset = 1'b1; opcode = LW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
        e = rec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, ADD, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b required %b", i, obs, e);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("lw_after_reset", LW, 3'd2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_alu();
        run_instr("add", RT, 3'd0, 1'b0, 1'b0, 0);
        run_instr("sub", RT, 3'd0, 1'b1, 1'b0, 0);
        for (int f = 1; f < 8; f++)
            run_instr("rtype_f3", RT, 3'(f), 1'b0, 1'b0, 0);
        run_instr("addi_f7", IT, 3'd0, 1'b1, 1'b0, 0);
        run_instr("xori", IT, 3'd4, 1'b0, 1'b1, 0);
        run_instr("srli", IT, 3'd5, 1'b1, 1'b0, 0);
    endtask

    task automatic test_mem();
        run_instr("lw", LW, 3'd2, 1'b0, 1'b1, 0);
        run_instr("sw", SW, 3'd2, 1'b0, 1'b0, 0);
        run_instr("jal", JL, 3'd0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", BR, 3'd0, 1'b0, 1'b1, 0);
        run_instr("beq_z0", BR, 3'd0, 1'b0, 1'b0, 0);
        run_instr("bne_z1", BR, 3'd1, 1'b0, 1'b1, 0);
        run_instr("bne_z0", BR, 3'd1, 1'b0, 1'b0, 0);
        run_instr("blt_z1", BR, 3'd4, 1'b0, 1'b1, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_ff", 7'b1111111, 3'd0, 1'b0, 1'b0, 0);
        run_instr("illegal_00", 7'b0000000, 3'd3, 1'b1, 1'b1, 0);
        run_instr("after_illegal", RT, 3'd7, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_midwrite();
        obs_t e;
        run_instr("sw_pre", SW, 3'd2, 1'b0, 1'b0, 3);
        #2;
        n_checks++;
        if (memWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL memwrite_before_reset: got %b required 1", memWrite);
        end
        reset = 1'b1;
        #1;
        e = rec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, ADD, 0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %b required %b", obs, e);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_held_edge: got %b required %b", obs, e);
        end
        reset = 1'b0;
        run_instr("sw_after_reset", SW, 3'd2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] op;
        ops = '{LW, SW, RT, IT, BR, JL};
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else                           op = ops[$urandom_range(0, 5)];
            run_instr("random", op, 3'($urandom), 1'($urandom), 1'($urandom), 0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal();
        test_reset_midwrite();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
